// File: rtl/priority_arbiter_rr_if.sv
// -----------------------------------------------------------------------------
// priority_arbiter_rr_if
//
// Bundle of the request side and the grant handshake of priority_arbiter_rr.
//
//   mode       : 0 = fixed priority (highest index wins), 1 = round-robin
//   req        : request vector, bit i = requester i
//   out_ready  : consumer accepts the presented grant
//   out_valid  : a grant is presented
//   out_idx    : binary index of the granted requester
//   out_onehot : one-hot of the granted requester, zero when out_valid = 0
//
// Modports:
//   slave  : the arbiter (takes requests, presents the grant)
//   master : the environment (drives requests and ready, observes the grant)
// -----------------------------------------------------------------------------
interface priority_arbiter_rr_if #(
  parameter int N = 8
);
  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic         mode;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] out_onehot;

  modport slave (
    input  mode,
    input  req,
    input  out_ready,
    output out_valid,
    output out_idx,
    output out_onehot
  );

  modport master (
    output mode,
    output req,
    output out_ready,
    input  out_valid,
    input  out_idx,
    input  out_onehot
  );
endinterface

// File: rtl/priority_arbiter_rr.sv
// -----------------------------------------------------------------------------
// priority_arbiter_rr
//
// Registered N-input priority arbiter with fixed-priority and round-robin
// modes and a valid/ready grant output. One winner is chosen per arbitration
// and held stable until the consumer accepts it.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : priority_arbiter_rr_if.slave (mode, req, out_ready in;
//          out_valid, out_idx, out_onehot out, all registered)
//
// Priority: the search starts at a pointer and runs downward, wrapping from
// 0 to N-1. Fixed mode always starts at N-1; round-robin starts at ptr, which
// moves to k-1 (or N-1 for k = 0) whenever a grant to k is accepted.
// -----------------------------------------------------------------------------
module priority_arbiter_rr #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  priority_arbiter_rr_if.slave bus
);
  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] TOP_IDX = W'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Registered state
  state_t       state_q;
  logic [W-1:0] ptr_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;

  // Next-state values
  state_t       state_d;
  logic [W-1:0] ptr_d;
  logic [W-1:0] idx_d;
  logic [N-1:0] onehot_d;

  // Arbitration helpers
  logic         accept;
  logic         arb_event;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] winner;

  // ---------------------------------------------------------------------------
  // Downward circular search from 'start'. The first set request bit met
  // wins; 'found' is low when no request is pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    for (int off = 0; off < N; off++) begin
      int           pos;
      logic [W-1:0] cand;
      pos = int'(start) - off;
      if (pos < 0) pos = pos + N;
      cand = W'(pos);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;

    accept    = (state_q == GRANT) && bus.out_ready;
    arb_event = (state_q == IDLE) || accept;

    // The pointer steps past the served requester before the search, so the
    // arbitration at an accept already sees the new priority order.
    if (accept && bus.mode) begin
      ptr_d = (idx_q == '0) ? TOP_IDX : idx_q - 1'b1;
    end

    start = bus.mode ? ptr_d : TOP_IDX;

    if (arb_event) begin
      if (found) begin
        state_d          = GRANT;
        idx_d            = winner;
        onehot_d         = '0;
        onehot_d[winner] = 1'b1;
      end else begin
        // Nothing to grant: drop valid, clear the one-hot, keep the index.
        state_d  = IDLE;
        onehot_d = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= TOP_IDX;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.out_valid  = (state_q == GRANT);
  assign bus.out_idx    = idx_q;
  assign bus.out_onehot = onehot_q;

  // ---------------------------------------------------------------------------
  // Invariants of the grant outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(onehot_q))
        else $error("out_onehot has more than one bit set");
      assert ((state_q != GRANT) || (onehot_q == (N'(1) << idx_q)))
        else $error("out_onehot does not match out_idx while valid");
      assert ((state_q == GRANT) || (onehot_q == '0))
        else $error("out_onehot nonzero while not valid");
    end
  end

endmodule

// File: doc/priority_arbiter_rr.md
# priority_arbiter_rr

Parametrised, registered N-input priority arbiter. It generalises our 4-input combinational priority encoder to N requesters, adds a round-robin mode and a valid/ready output handshake. It sits between request sources (DMA channels, interrupt lines) and a single shared consumer. It chooses one winner per arbitration, encodes it as a binary index plus a one-hot vector, and holds that grant stable until the consumer accepts it.

## Interface
- `N`, default 8: number of requesters; legal range 2..32.
- `W`, default `$clog2(N)`: index width; derived, not overridden.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: synchronous reset, active-high.
- `mode` input, 1: 0 = fixed priority (highest index wins); 1 = round-robin.
- `req` input, N: request vector; bit i = requester i.
- `out_ready` input, 1: consumer accepts the current grant.
- `out_valid` output, 1: a grant is presented.
- `out_idx` output, W: binary index of the granted requester.
- `out_onehot` output, N: one-hot of the granted requester; 0 when `out_valid` = 0.

## Operation
- State machine has two states:
  - IDLE: `out_valid` = 0.
  - GRANT: `out_valid` = 1.
- Pointer `ptr` (W bits) names the highest-priority index. The search runs downward from `ptr` and wraps from 0 to N-1.
- Fixed mode: the search always starts at N-1. For N = 4 this matches the legacy encoder: D[3] > D[2] > D[1] > D[0]. `ptr` is not updated in fixed mode.
- Round-robin mode: the search starts at `ptr`. On each accepted grant to index k, `ptr` becomes k-1, or N-1 when k = 0.
- Arbitration event: occurs in IDLE, or in GRANT on an accept cycle (`out_valid` & `out_ready`).
  - If `|req` = 1 at the event: register the winner into `out_idx`/`out_onehot` and go to (or stay in) GRANT.
  - Otherwise: go to IDLE, clear `out_onehot`, hold `out_idx`.
- The arbitration event at an accept uses the already-updated `ptr` value (k-1 rule), so the just-served requester is never re-granted back-to-back while others request.
- Grant is sticky. While in GRANT and `out_ready` = 0:
  - `out_idx`, `out_onehot` and `out_valid` are frozen.
  - `req` changes are ignored, including deassertion of the granted bit.
- `mode` is sampled only at arbitration events. Changing it mid-grant has no effect on the held grant.
- `ptr` is retained across a round-robin → fixed → round-robin mode switch.
- `out_onehot` is always either zero or exactly one-hot, and equals `1 << out_idx` whenever `out_valid` = 1.

## Timing
- Reset (`rst` = 1 at a rising edge) sets, on that edge:
  - `out_valid` = 0, `out_idx` = 0, `out_onehot` = 0.
  - `ptr` = N-1, state = IDLE.
- Reset overrides every other input. Reset mid-grant discards the grant without an accept, and `ptr` does not advance.
- Latency: `req` sampled in IDLE at edge t gives `out_valid` = 1 with the winner after edge t. All outputs are registered; there is no combinational path from input to output.
- Throughput: one grant per cycle when `out_ready` is held at 1 and requests persist, with no bubble between grants.
- Accept with `req` = 0 in that cycle: `out_valid` drops after that edge.
- A request arriving in the same cycle as an accept participates in that cycle's arbitration.

## Test plan
- Fixed priority (N=8, `mode`=0, `out_ready`=0), `req`=8'b0010_1100 in IDLE → next cycle `out_valid`=1, `out_idx`=5, `out_onehot`=8'b0010_0000.
- Backpressure: from the previous state, hold `out_ready`=0 for 3 cycles while `req` changes to 8'b0000_0001 → `out_idx` stays 5 and `out_valid` stays 1. Then pulse `out_ready`=1 → next cycle `out_idx`=0.
- Round-robin rotation (`mode`=1, `req`=8'hFF, `out_ready`=1) → grants 7,6,5,4,3,2,1,0,7 on consecutive cycles with no bubble.
- Round-robin fairness with wrap: after a grant to 0 is accepted (`ptr`=7), `req`=8'b1000_0001 → grants alternate 7,0,7,0. In fixed mode with the same stimulus → 7 every cycle.
- Empty and drain cases:
  - `req`=0 in IDLE → `out_valid` remains 0.
  - Accept with `req`=0 → `out_valid`=0 on the next cycle and `out_onehot`=0.
- Reset mid-operation: assert `rst` while a grant to index 3 is held with `out_ready`=0 → next cycle `out_valid`=0, `out_onehot`=0, `out_idx`=0. The first round-robin grant after release with `req`=8'hFF is 7.
